spi_slave_rx: RTL and testbench

- SPI slave endpoint that sits directly downstream of the FPGA SPI master, on the far side of the sclk/cs/MOSI/MISO wires.
- Oversamples the SPI pins with the system clock, deserialises MOSI into bytes and serialises a local transmit byte onto MISO.
- Mode 0, MSB first: sclk idles low; data is sampled on the sclk rising edge and changed on the sclk falling edge; cs is active-low.
- Supports multi-byte frames while cs stays low, and flags truncated frames.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_rx.sv | 143 ++++++++++++++
 tb/tb_spi_slave_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM encoding, default widths
// and the CPOL/CPHA mode constants used by master and slave.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchroniser with one extra history flop
// that turns the synced level into rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_rx.sv
// Mode-0 SPI slave: oversampled pins, MSB-first RX
// deserialiser and TX serialiser, truncated-frame flag.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W-1);

  spi_state_t r_state, w_state_n;

  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] r_tx_shift;

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused_edges;

  logic w_start, w_stop, w_rise, w_fall;
  logic [DATA_W-1:0] w_rx_next;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(CPOL)
  ) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (sclk),
    .o_level(w_sclk_lvl),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (cs),
    .o_level(w_cs_lvl),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync_mosi (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (MOSI),
    .o_level(w_mosi),
    .o_rise (w_mosi_rise),
    .o_fall (w_mosi_fall)
  );

  assign w_unused_edges = w_mosi_rise ^ w_mosi_fall
                        ^ w_sclk_lvl ^ w_cs_lvl;

  // cs deassertion wins over an sclk edge seen in the same cycle
  assign w_start = (r_state == IDLE)  & w_cs_fall;
  assign w_stop  = (r_state == SHIFT) & w_cs_rise;
  assign w_rise  = (r_state == SHIFT) & ~w_cs_rise & w_sclk_rise;
  assign w_fall  = (r_state == SHIFT) & ~w_cs_rise & w_sclk_fall;

  assign w_rx_next = {r_rx_shift[DATA_W-2:0], w_mosi};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE:    if (w_cs_fall) w_state_n = SHIFT;
      SHIFT:   if (w_cs_rise) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MISO       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (1'b1)
        w_start: begin
          r_tx_shift <= tx_data;
          MISO       <= tx_data[DATA_W-1];
          r_bit_cnt  <= '0;
          r_rx_shift <= '0;
        end
        w_stop: begin
          MISO <= 1'b0;
          if (r_bit_cnt != '0) frame_err <= 1'b1;
        end
        w_rise: begin
          r_rx_shift <= w_rx_next;
          if (r_bit_cnt == LAST) begin
            rx_data    <= w_rx_next;
            rx_valid   <= 1'b1;
            r_bit_cnt  <= '0;
            r_tx_shift <= tx_data;
          end else begin
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
          end
        end
        w_fall: MISO <= r_tx_shift[DATA_W-1];
        default: ;
      endcase
    end
  end

  assign busy = (r_state == SHIFT);

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: bench drives the SPI pins as
// master; a scoreboard monitor checks rx bytes/frame errors.
module tb_spi_slave_rx;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int n_rxv = 0;
  int n_ferr = 0;
  int ferr_exp = 0;
  logic [7:0] exp_q[$];

  spi_slave_rx #(
    .DATA_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs       (cs),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid) begin
        n_rxv++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_rx: got %0h required none", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            fails++;
            $display("FAIL sb_rx: got %0h required %0h", rx_data, e);
          end
        end
      end
      if (frame_err) begin
        n_ferr++;
        tests++;
        if (ferr_exp > 0) ferr_exp--;
        else begin
          fails++;
          $display("FAIL sb_ferr: got 1 required 0");
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_byte(input logic [7:0] d,
                           input logic [7:0] tx_next,
                           input int nbits, input bit lat,
                           output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = d[7-i];
      if (i == 7) tx_data = tx_next;
      wait_clk(HALF);
      sclk = 1'b1;
      got = {got[6:0], MISO};
      if (lat && i == 7) begin
        wait_clk(2);
        check("lat_pre", 32'(rx_valid), 0);
        wait_clk(1);
        check("lat_hit", 32'(rx_valid), 1);
        wait_clk(1);
        check("lat_post", 32'(rx_valid), 0);
        wait_clk(HALF - 4);
      end else begin
        wait_clk(HALF);
      end
      sclk = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] g;
    int rxv0, ferr0;

    wait_clk(3);
    check("rst_miso", 32'(MISO), 0);
    check("rst_rxd", 32'(rx_data), 0);
    check("rst_rxv", 32'(rx_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ferr", 32'(frame_err), 0);
    rst = 1'b1;
    wait_clk(5);

    // Loopback with latency probe on the 8th rise
    tx_data = 8'h3C;
    exp_q.push_back(8'hA5);
    rxv0 = n_rxv;
    cs_low();
    check("busy_on", 32'(busy), 1);
    send_byte(8'hA5, 8'h3C, 8, 1'b1, g);
    check("loop_miso", 32'(g), 32'h3C);
    cs_high();
    check("loop_rxd", 32'(rx_data), 32'hA5);
    check("loop_nrxv", 32'(n_rxv - rxv0), 1);
    check("busy_off", 32'(busy), 0);

    // Two-byte frame, tx byte swapped before the boundary
    tx_data = 8'h80;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    cs_low();
    send_byte(8'h01, 8'h7E, 8, 1'b0, g);
    check("two_miso0", 32'(g), 32'h80);
    send_byte(8'hFF, 8'h7E, 8, 1'b0, g);
    check("two_miso1", 32'(g), 32'h7E);
    cs_high();
    check("two_rxd", 32'(rx_data), 32'hFF);

    // Truncated frame after 5 bits
    tx_data = 8'hB7;
    rxv0 = n_rxv;
    ferr0 = n_ferr;
    ferr_exp++;
    cs_low();
    send_byte(8'h5A, 8'hB7, 5, 1'b0, g);
    check("trunc_miso", 32'(g), 32'h16);
    cs_high();
    check("trunc_ferr", 32'(n_ferr - ferr0), 1);
    check("trunc_rxv", 32'(n_rxv - rxv0), 0);
    check("trunc_rxd", 32'(rx_data), 32'hFF);
    check("trunc_miso0", 32'(MISO), 0);
    check("trunc_busy", 32'(busy), 0);

    // Reset mid-frame after 3 bits with MISO high
    tx_data = 8'hFF;
    cs_low();
    send_byte(8'hE0, 8'hFF, 3, 1'b0, g);
    wait_clk(HALF);
    check("pre_rst_miso", 32'(MISO), 1);
    rst = 1'b0;
    #1;
    check("mrst_miso", 32'(MISO), 0);
    check("mrst_rxd", 32'(rx_data), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_rxv", 32'(rx_valid), 0);
    check("mrst_ferr", 32'(frame_err), 0);
    cs = 1'b1;
    MOSI = 1'b0;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(4);
    tx_data = 8'h5A;
    exp_q.push_back(8'hC3);
    cs_low();
    send_byte(8'hC3, 8'h5A, 8, 1'b0, g);
    check("post_rst_miso", 32'(g), 32'h5A);
    cs_high();
    check("post_rst_rxd", 32'(rx_data), 32'hC3);

    // Idle sclk noise with cs high
    rxv0 = n_rxv;
    for (int i = 0; i < 10; i++) begin
      sclk = 1'b1;
      wait_clk(HALF);
      check("idle_miso", 32'(MISO), 0);
      check("idle_busy", 32'(busy), 0);
      sclk = 1'b0;
      wait_clk(HALF);
    end
    check("idle_nrxv", 32'(n_rxv - rxv0), 0);

    wait_clk(10);
    check("sb_drained", 32'(exp_q.size()), 0);
    check("ferr_drained", 32'(ferr_exp), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
